// File: rtl/rs_latch_driver_pkg.sv
// ============================================================================
// Module  : rs_latch_driver_pkg
// Desc    : Shared opcode constants and FSM state encoding for the latch driver.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_latch_driver_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    function automatic logic is_timed_op(input logic [1:0] op);
        return (op == OP_SET) || (op == OP_RST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ============================================================================
// Module  : cycle_timer
// Desc    : Loadable 4-bit down-counter; o_tc is high while the count is zero.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_tc
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_tc = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/rs_latch_driver.sv
// ============================================================================
// Module  : rs_latch_driver
// Desc    : Sequences setup/pulse/hold on a gated RS latch and checks readback.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_latch_driver
    import rs_latch_driver_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Req_valid,
    input  logic [1:0] Req_op,
    output logic       Req_ready,
    output logic       Lat_R,
    output logic       Lat_S,
    output logic       Lat_Enable,
    input  logic       Lat_Q,
    input  logic       Lat_Q_pr,
    output logic       Done,
    output logic       Err
);

    // Timer reload values: a state lasting N cycles counts N-1 down to zero.
    localparam logic [3:0] c_setup_ld = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_pulse_ld = 4'(PULSE_CYC - 1);
    localparam logic [3:0] c_hold_ld  = 4'(HOLD_CYC - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_op;
    logic       r_ready;
    logic       r_lat_r;
    logic       r_lat_s;
    logic       r_lat_en;
    logic       r_done;
    logic       r_err;

    logic       w_accept;
    logic       w_load;
    logic [3:0] w_load_val;
    logic       w_tc;
    logic       w_err_next;
    logic       w_drive;
    logic [1:0] w_op_next;

    cycle_timer u_cycle_timer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    assign w_accept = (r_state == ST_IDLE) && r_ready && Req_valid;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 4'd0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_timed_op(Req_op)) begin
                        w_next_state = ST_SETUP;
                        w_load       = 1'b1;
                        w_load_val   = c_setup_ld;
                    end else begin
                        w_next_state = ST_CHECK;
                        w_err_next   = (Req_op == OP_ILL);
                    end
                end
            end
            ST_SETUP: begin
                if (w_tc) begin
                    w_next_state = ST_PULSE;
                    w_load       = 1'b1;
                    w_load_val   = c_pulse_ld;
                end
            end
            ST_PULSE: begin
                if (w_tc) begin
                    w_next_state = ST_HOLD;
                    w_load       = 1'b1;
                    w_load_val   = c_hold_ld;
                end
            end
            ST_HOLD: begin
                // Readback is judged on the final HOLD edge, once the latch has settled.
                if (w_tc) begin
                    w_next_state = ST_CHECK;
                    w_err_next   = (Lat_Q != (r_op == OP_SET)) || (Lat_Q == Lat_Q_pr);
                end
            end
            ST_CHECK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state itself.
    assign w_drive   = (w_next_state == ST_SETUP) || (w_next_state == ST_PULSE) ||
                       (w_next_state == ST_HOLD);
    assign w_op_next = w_accept ? Req_op : r_op;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_NOP;
            r_ready  <= 1'b0;
            r_lat_r  <= 1'b0;
            r_lat_s  <= 1'b0;
            r_lat_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            if (w_accept) begin
                r_op <= Req_op;
            end
            r_ready  <= (w_next_state == ST_IDLE);
            r_lat_s  <= w_drive && (w_op_next == OP_SET);
            r_lat_r  <= w_drive && (w_op_next == OP_RST);
            r_lat_en <= (w_next_state == ST_PULSE);
            r_done   <= (w_next_state == ST_CHECK);
            r_err    <= w_err_next;
        end
    end

    assign Req_ready  = r_ready;
    assign Lat_R      = r_lat_r;
    assign Lat_S      = r_lat_s;
    assign Lat_Enable = r_lat_en;
    assign Done       = r_done;
    assign Err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rs_latch_driver.sv
// ============================================================================
// Module  : tb_rs_latch_driver
// Desc    : Randomized scoreboard bench for rs_latch_driver with a latch model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_latch_driver;
    import rs_latch_driver_pkg::*;

    localparam int S = 1, P = 2, H = 1;
    localparam int S2 = 3, P2 = 1, H2 = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Req_valid;
    logic [1:0] Req_op;
    logic       Req_ready, Lat_R, Lat_S, Lat_Enable, Lat_Q, Lat_Q_pr, Done, Err;

    logic       v2;
    logic [1:0] op2;
    logic       ready2, r2, s2, en2, q2, qpr2, done2, err2;

    always #5 Clk = ~Clk;

    // Gated RS latch model with fault injection on the readback.
    logic lq = 1'b0, lq2 = 1'b0;
    bit   stuck_en = 0, stuck_val = 0, qpr_bad = 0;
    always @(negedge Clk) begin
        if (Lat_Enable && Lat_S && !Lat_R) lq = 1'b1;
        else if (Lat_Enable && Lat_R && !Lat_S) lq = 1'b0;
        if (en2 && s2 && !r2) lq2 = 1'b1;
        else if (en2 && r2 && !s2) lq2 = 1'b0;
    end
    assign Lat_Q    = stuck_en ? stuck_val : lq;
    assign Lat_Q_pr = qpr_bad ? Lat_Q : ~Lat_Q;
    assign q2       = lq2;
    assign qpr2     = ~lq2;

    rs_latch_driver dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req_valid(Req_valid), .Req_op(Req_op),
        .Req_ready(Req_ready), .Lat_R(Lat_R), .Lat_S(Lat_S), .Lat_Enable(Lat_Enable),
        .Lat_Q(Lat_Q), .Lat_Q_pr(Lat_Q_pr), .Done(Done), .Err(Err)
    );

    rs_latch_driver #(.SETUP_CYC(S2), .PULSE_CYC(P2), .HOLD_CYC(H2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Req_valid(v2), .Req_op(op2),
        .Req_ready(ready2), .Lat_R(r2), .Lat_S(s2), .Lat_Enable(en2),
        .Lat_Q(q2), .Lat_Q_pr(qpr2), .Done(done2), .Err(err2)
    );

    typedef struct {
        int         start;
        int         lat;
        logic [1:0] op;
        logic       err;
    } txn_t;

    txn_t       sb[$];
    int         cyc = 0;
    int         last_done_cyc = 0;
    bit         warm = 0;
    bit         pend = 0;
    logic [1:0] pend_op = 2'b00;
    int         tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int latency(input logic [1:0] op);
        return ((op == OP_SET) || (op == OP_RST)) ? 1 + S + P + H : 1;
    endfunction

    function automatic logic exp_err(input logic [1:0] op);
        logic q_fin, qpr;
        if (op == OP_NOP) return 1'b0;
        if (op == OP_ILL) return 1'b1;
        q_fin = stuck_en ? stuck_val : (op == OP_SET);
        qpr   = qpr_bad ? q_fin : ~q_fin;
        return (q_fin != (op == OP_SET)) || (q_fin == qpr);
    endfunction

    // Handshake observed on the falling edge, turned into a scoreboard entry on the rise.
    always @(negedge Clk) begin
        pend    = Reset_n && Req_valid && Req_ready;
        pend_op = Req_op;
    end

    always @(posedge Clk) begin
        txn_t t;
        cyc++;
        if (!Reset_n) begin
            sb.delete();
            warm = 0;
        end else begin
            if (pend) begin
                t.start = cyc;
                t.lat   = latency(pend_op);
                t.op    = pend_op;
                t.err   = exp_err(pend_op);
                sb.push_back(t);
            end
            warm = 1;
        end
    end

    logic prev_r = 1'b0, prev_s = 1'b0, prev_en = 1'b0;
    always @(negedge Clk) begin
        int   k;
        bit   busy, timed;
        logic exp_s, exp_r, exp_en;
        if (Reset_n && warm) begin
            busy   = (sb.size() > 0);
            k      = busy ? cyc - sb[0].start + 1 : 0;
            timed  = busy && ((sb[0].op == OP_SET) || (sb[0].op == OP_RST));
            exp_s  = busy && (sb[0].op == OP_SET) && (k >= 1) && (k <= S + P + H);
            exp_r  = busy && (sb[0].op == OP_RST) && (k >= 1) && (k <= S + P + H);
            exp_en = timed && (k >= S + 1) && (k <= S + P);
            chk("ready", Req_ready, !busy);
            chk("lat_s", Lat_S, exp_s);
            chk("lat_r", Lat_R, exp_r);
            chk("lat_en", Lat_Enable, exp_en);
            chk("rs_exclusive", Lat_R && Lat_S, 0);
            if (Lat_Enable || prev_en) chk("rs_stable_around_en", {Lat_R, Lat_S}, {prev_r, prev_s});
            if (Done) begin
                last_done_cyc = cyc;
                if (!busy) begin
                    chk("done_unexpected", Done, 0);
                end else begin
                    chk("done_latency", k, sb[0].lat);
                    chk("err", Err, sb[0].err);
                    void'(sb.pop_front());
                end
            end else if (busy && k >= sb[0].lat) begin
                chk("done_missing", Done, 1);
                void'(sb.pop_front());
            end
        end
        prev_r  = Lat_R;
        prev_s  = Lat_S;
        prev_en = Lat_Enable;
    end

    task automatic issue(input logic [1:0] op);
        int n = 0;
        Req_valid = 1'b1;
        Req_op    = op;
        @(negedge Clk);
        while (!Req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!Req_ready) chk("accept_timeout", Req_ready, 1);
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        Req_op    = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while ((sb.size() != 0 || !Req_ready) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!Req_ready) chk("idle_timeout", Req_ready, 1);
    endtask

    initial begin
        int n, k;
        Reset_n = 1'b0; Req_valid = 1'b0; Req_op = OP_NOP; v2 = 1'b0; op2 = OP_NOP;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", Req_ready, 0);
        chk("rst_lat_r", Lat_R, 0);
        chk("rst_lat_s", Lat_S, 0);
        chk("rst_lat_en", Lat_Enable, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("ready_after_reset", Req_ready, 1);

        // Directed: set from Q=0, reset against stuck Q=1, nop, illegal, broken Q_pr.
        issue(OP_SET);  wait_idle();
        chk("latch_q_after_set", lq, 1);
        stuck_en = 1; stuck_val = 1;
        issue(OP_RST);  wait_idle();
        stuck_en = 0;
        issue(OP_NOP);  wait_idle();
        issue(OP_ILL);  wait_idle();
        qpr_bad = 1;
        issue(OP_SET);  wait_idle();
        qpr_bad = 0;

        for (int i = 0; i < 60; i++) begin
            n         = $urandom_range(0, 9);
            stuck_en  = (n == 0);
            stuck_val = 1'($urandom);
            qpr_bad   = (n == 1);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            issue(2'($urandom_range(0, 3)));
            wait_idle();
        end
        stuck_en = 0; qpr_bad = 0;

        // Valid held high with alternating ops: each accept one cycle after the Done.
        Req_valid = 1'b1;
        Req_op    = OP_SET;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            @(negedge Clk);
            while (!Req_ready && n < 50) begin
                @(negedge Clk);
                n++;
            end
            @(posedge Clk);
            #1;
            if (i > 0) chk("b2b_accept_gap", cyc - last_done_cyc, 2);
            Req_op = (Req_op == OP_SET) ? OP_RST : OP_SET;
        end
        Req_valid = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of PULSE.
        issue(OP_SET);
        @(posedge Clk);
        #2;
        chk("pulse_before_reset", Lat_Enable, 1);
        Reset_n = 1'b0;
        #1;
        chk("abort_lat_r", Lat_R, 0);
        chk("abort_lat_s", Lat_S, 0);
        chk("abort_lat_en", Lat_Enable, 0);
        chk("abort_done", Done, 0);
        chk("abort_err", Err, 0);
        chk("abort_ready", Req_ready, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("ready_after_abort", Req_ready, 1);
        repeat (8) @(negedge Clk);

        // Non-default timing: 1 + 3 + 1 + 2 cycles from accept to Done.
        v2  = 1'b1;
        op2 = OP_SET;
        n   = 0;
        @(negedge Clk);
        while (!ready2 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        @(posedge Clk);
        #1;
        v2 = 1'b0;
        k  = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!done2 && k < 30);
        chk("dut2_done_latency", k, 1 + S2 + P2 + H2);
        chk("dut2_err", err2, 0);
        chk("dut2_latch_q", lq2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
